// File: rtl/afifo_arb_pkg.sv
// Shared types and helpers for the async-FIFO write-port arbiter:
// FSM state encoding, burst counter sizing and the round-robin search.
package afifo_arb_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  // Upper bound on requesters the round-robin search supports.
  localparam int RR_MAX   = 32;
  localparam int RR_IDX_W = 5;

  typedef struct packed {
    logic                valid;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  function automatic int cnt_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

  localparam int DEFAULT_MAX_BURST = 4;
  localparam int DEFAULT_CNT_W     = cnt_width(DEFAULT_MAX_BURST);

  // First set bit of req searching ptr+1, ptr+2, ... (mod nreq); ptr itself is checked last.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] req,
                                       input logic [31:0]       ptr,
                                       input int unsigned       nreq);
    rr_pick_t    r;
    logic [31:0] idx;
    r = '0;
    for (int unsigned i = 1; i <= RR_MAX; i++) begin
      idx = (ptr + i) % nreq;
      if ((i <= nreq) && !r.valid && req[idx[RR_IDX_W-1:0]]) begin
        r.valid = 1'b1;
        r.idx   = idx[RR_IDX_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/afifo_rr_picker.sv
// Combinational round-robin winner selection among NREQ requesters (NREQ <= 32),
// starting the search just after ptr.
module afifo_rr_picker
  import afifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   winner,
  output logic            valid
);

  logic [RR_MAX-1:0] req_w;
  rr_pick_t          pick;

  always_comb begin
    req_w            = '0;
    req_w[NREQ-1:0]  = req;
    pick             = rr_pick(req_w, 32'(ptr), NREQ);
    winner           = pick.idx[IW-1:0];
    valid            = pick.valid;
  end

endmodule

// File: rtl/afifo_wr_arbiter.sv
// Round-robin, burst-bounded arbiter sharing the async FIFO write port among
// NREQ producers in the write clock domain.
module afifo_wr_arbiter
  import afifo_arb_pkg::*;
#(
  parameter int DSIZE     = 8,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
  input  logic                     wr_clk,
  input  logic                     wr_rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DSIZE-1:0]    req_data,
  input  logic [NREQ-1:0]          req_last,
  input  logic                     wr_full,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          ack,
  output logic                     wr_inc,
  output logic [DSIZE-1:0]         wr_data,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  cur_id
);

  localparam int IW    = $clog2(NREQ);
  localparam int CNT_W = cnt_width(MAX_BURST);

  arb_state_t       state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [IW-1:0]    cur_id_q, cur_id_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             transfer;
  logic             last_word;
  logic             burst_end;
  logic [NREQ-1:0]  arb_req;
  logic [IW-1:0]    win;
  logic             win_valid;

  // A requester that just sent its marked last word must not win the next grant.
  always_comb begin
    transfer  = (state_q == GRANT) && req[cur_id_q] && !wr_full;
    last_word = transfer && (req_last[cur_id_q] || (cnt_q == CNT_W'(MAX_BURST - 1)));
    burst_end = (state_q == GRANT) && (last_word || !req[cur_id_q]);
    arb_req   = req;
    if (transfer && req_last[cur_id_q]) begin
      arb_req[cur_id_q] = 1'b0;
    end
  end

  afifo_rr_picker #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_picker (
    .req    (arb_req),
    .ptr    (ptr_q),
    .winner (win),
    .valid  (win_valid)
  );

  assign wr_inc  = transfer && !wr_rst;
  assign ack     = gnt_q & {NREQ{wr_inc}};
  assign wr_data = req_data[cur_id_q*DSIZE +: DSIZE];
  assign gnt     = gnt_q;
  assign busy    = (state_q == GRANT);
  assign cur_id  = cur_id_q;

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    cur_id_d = cur_id_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d    = GRANT;
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          cur_id_d   = win;
          ptr_d      = win;
          cnt_d      = '0;
        end
      end
      GRANT: begin
        if (burst_end) begin
          if (win_valid) begin
            gnt_d      = '0;
            gnt_d[win] = 1'b1;
            cur_id_d   = win;
            ptr_d      = win;
            cnt_d      = '0;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            cnt_d   = '0;
          end
        end else if (transfer) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      cur_id_q <= '0;
      ptr_q    <= IW'(NREQ - 1);
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      cur_id_q <= cur_id_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_afifo_wr_arbiter.sv
// Directed, self-checking bench for afifo_wr_arbiter (DSIZE=8, NREQ=4, MAX_BURST=4).
module tb_afifo_wr_arbiter;

  logic        wr_clk;
  logic        wr_rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic        wr_full;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic        wr_inc;
  logic [7:0]  wr_data;
  logic        busy;
  logic [1:0]  cur_id;

  int checks;
  int errors;

  afifo_wr_arbiter #(
    .DSIZE     (8),
    .NREQ      (4),
    .MAX_BURST (4)
  ) dut (
    .wr_clk   (wr_clk),
    .wr_rst   (wr_rst),
    .req      (req),
    .req_data (req_data),
    .req_last (req_last),
    .wr_full  (wr_full),
    .gnt      (gnt),
    .ack      (ack),
    .wr_inc   (wr_inc),
    .wr_data  (wr_data),
    .busy     (busy),
    .cur_id   (cur_id)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to just after the next rising edge; inputs change here, outputs are sampled #1 later.
  task automatic cyc();
    @(posedge wr_clk);
    #2;
  endtask

  task automatic do_reset();
    wr_rst   = 1'b1;
    req      = '0;
    req_last = '0;
    wr_full  = 1'b0;
    cyc();
    wr_rst   = 1'b0;
  endtask

  task automatic test_reset();
    wr_rst   = 1'b1;
    req      = '0;
    req_last = '0;
    wr_full  = 1'b0;
    req_data = 32'h0;
    cyc();
    #1;
    checks++;
    if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL reset_gnt: got %b expected %b", gnt, 4'b0000); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected %b", busy, 1'b0); end
    checks++;
    if (cur_id !== 2'd0) begin errors++; $display("[TB] FAIL reset_cur_id: got %0d expected %0d", cur_id, 0); end
    req = 4'b1111;
    #1;
    checks++;
    if (wr_inc !== 1'b0 || ack !== 4'b0000) begin
      errors++; $display("[TB] FAIL reset_no_write: got wr_inc=%b ack=%b expected 0/0000", wr_inc, ack);
    end
    req    = '0;
    wr_rst = 1'b0;
  endtask

  task automatic test_single_stream();
    logic [7:0] words [3];
    words[0] = 8'hA1; words[1] = 8'hA2; words[2] = 8'hA3;
    do_reset();
    req      = 4'b0001;
    req_data = {24'h0, words[0]};
    #1;
    checks++;
    if (wr_inc !== 1'b0 || gnt !== 4'b0000) begin
      errors++; $display("[TB] FAIL single_idle: got wr_inc=%b gnt=%b expected 0/0000", wr_inc, gnt);
    end
    for (int k = 0; k < 3; k++) begin
      cyc();
      req_data = {24'h0, words[k]};
      req_last = (k == 2) ? 4'b0001 : 4'b0000;
      #1;
      checks++;
      if (gnt !== 4'b0001 || ack !== 4'b0001) begin
        errors++; $display("[TB] FAIL single_gnt_%0d: got gnt=%b ack=%b expected 0001/0001", k, gnt, ack);
      end
      checks++;
      if (wr_inc !== 1'b1 || wr_data !== words[k]) begin
        errors++; $display("[TB] FAIL single_word_%0d: got wr_inc=%b data=%h expected 1/%h", k, wr_inc, wr_data, words[k]);
      end
    end
    cyc();
    req      = '0;
    req_last = '0;
    #1;
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || wr_inc !== 1'b0) begin
      errors++; $display("[TB] FAIL single_release: got gnt=%b busy=%b wr_inc=%b expected 0000/0/0", gnt, busy, wr_inc);
    end
  endtask

  task automatic test_full_rotation();
    logic [1:0] exp_id [5];
    logic [7:0] exp_data;
    exp_id[0] = 2'd0; exp_id[1] = 2'd1; exp_id[2] = 2'd2; exp_id[3] = 2'd3; exp_id[4] = 2'd0;
    do_reset();
    req      = 4'b1111;
    req_data = 32'h44332211;
    cyc();
    for (int g = 0; g < 5; g++) begin
      for (int k = 0; k < 4; k++) begin
        #1;
        exp_data = 8'h11 * (8'(exp_id[g]) + 8'd1);
        checks++;
        if (cur_id !== exp_id[g] || gnt !== (4'b0001 << exp_id[g])) begin
          errors++; $display("[TB] FAIL rot_id_g%0d_w%0d: got cur_id=%0d gnt=%b expected %0d", g, k, cur_id, gnt, exp_id[g]);
        end
        checks++;
        if (wr_inc !== 1'b1 || wr_data !== exp_data) begin
          errors++; $display("[TB] FAIL rot_write_g%0d_w%0d: got wr_inc=%b data=%h expected 1/%h", g, k, wr_inc, wr_data, exp_data);
        end
        cyc();
      end
    end
    req = '0;
  endtask

  task automatic test_stall();
    do_reset();
    req      = 4'b0100;
    req_data = 32'h00500000;
    cyc();
    for (int k = 0; k < 2; k++) begin
      req_data = {8'h00, 8'h50 + 8'(k), 16'h0000};
      #1;
      checks++;
      if (wr_inc !== 1'b1 || wr_data !== 8'h50 + 8'(k)) begin
        errors++; $display("[TB] FAIL stall_pre_%0d: got wr_inc=%b data=%h expected 1/%h", k, wr_inc, wr_data, 8'h50 + 8'(k));
      end
      cyc();
    end
    wr_full  = 1'b1;
    req      = 4'b0101;
    req_data = {8'h00, 8'h52, 8'h00, 8'h99};
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (wr_inc !== 1'b0 || ack !== 4'b0000 || gnt !== 4'b0100) begin
        errors++; $display("[TB] FAIL stall_hold_%0d: got wr_inc=%b ack=%b gnt=%b expected 0/0000/0100", k, wr_inc, ack, gnt);
      end
      cyc();
    end
    wr_full = 1'b0;
    for (int k = 2; k < 4; k++) begin
      req_data = {8'h00, 8'h50 + 8'(k), 8'h00, 8'h99};
      #1;
      checks++;
      if (wr_inc !== 1'b1 || gnt !== 4'b0100 || wr_data !== 8'h50 + 8'(k)) begin
        errors++; $display("[TB] FAIL stall_post_%0d: got wr_inc=%b gnt=%b data=%h expected 1/0100/%h", k, wr_inc, gnt, wr_data, 8'h50 + 8'(k));
      end
      cyc();
    end
    #1;
    checks++;
    if (gnt !== 4'b0001 || cur_id !== 2'd0 || wr_data !== 8'h99) begin
      errors++; $display("[TB] FAIL stall_rotate: got gnt=%b cur_id=%0d data=%h expected 0001/0/99", gnt, cur_id, wr_data);
    end
    req = '0;
  endtask

  task automatic test_early_drop();
    do_reset();
    req      = 4'b1010;
    req_data = 32'hD0_00_B0_00;
    cyc();
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (gnt !== 4'b0010 || wr_inc !== 1'b1 || wr_data !== 8'hB0) begin
        errors++; $display("[TB] FAIL drop_word_%0d: got gnt=%b wr_inc=%b data=%h expected 0010/1/b0", k, gnt, wr_inc, wr_data);
      end
      cyc();
    end
    req = 4'b1000;
    #1;
    checks++;
    if (wr_inc !== 1'b0 || ack !== 4'b0000) begin
      errors++; $display("[TB] FAIL drop_no_write: got wr_inc=%b ack=%b expected 0/0000", wr_inc, ack);
    end
    cyc();
    #1;
    checks++;
    if (gnt !== 4'b1000 || cur_id !== 2'd3 || wr_data !== 8'hD0 || ack !== 4'b1000) begin
      errors++; $display("[TB] FAIL drop_regrant: got gnt=%b cur_id=%0d data=%h ack=%b expected 1000/3/d0/1000", gnt, cur_id, wr_data, ack);
    end
    req = '0;
  endtask

  task automatic test_last_under_full();
    do_reset();
    req      = 4'b0001;
    req_last = 4'b0001;
    req_data = 32'h00000071;
    wr_full  = 1'b1;
    cyc();
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (gnt !== 4'b0001 || wr_inc !== 1'b0) begin
        errors++; $display("[TB] FAIL lastfull_hold_%0d: got gnt=%b wr_inc=%b expected 0001/0", k, gnt, wr_inc);
      end
      cyc();
    end
    wr_full = 1'b0;
    #1;
    checks++;
    if (wr_inc !== 1'b1 || wr_data !== 8'h71) begin
      errors++; $display("[TB] FAIL lastfull_write: got wr_inc=%b data=%h expected 1/71", wr_inc, wr_data);
    end
    cyc();
    req      = '0;
    req_last = '0;
    #1;
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL lastfull_release: got gnt=%b busy=%b expected 0000/0", gnt, busy);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req      = 4'b0100;
    req_data = 32'h00C20000;
    cyc();
    #1;
    checks++;
    if (gnt !== 4'b0100 || wr_inc !== 1'b1) begin
      errors++; $display("[TB] FAIL rstmid_burst: got gnt=%b wr_inc=%b expected 0100/1", gnt, wr_inc);
    end
    cyc();
    wr_rst = 1'b1;
    #1;
    checks++;
    if (wr_inc !== 1'b0 || ack !== 4'b0000) begin
      errors++; $display("[TB] FAIL rstmid_force: got wr_inc=%b ack=%b expected 0/0000", wr_inc, ack);
    end
    cyc();
    #1;
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || cur_id !== 2'd0) begin
      errors++; $display("[TB] FAIL rstmid_clear: got gnt=%b busy=%b cur_id=%0d expected 0000/0/0", gnt, busy, cur_id);
    end
    wr_rst = 1'b0;
    req    = 4'b1111;
    cyc();
    #1;
    checks++;
    if (gnt !== 4'b0001 || cur_id !== 2'd0) begin
      errors++; $display("[TB] FAIL rstmid_winner: got gnt=%b cur_id=%0d expected 0001/0", gnt, cur_id);
    end
    req = '0;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    wr_rst   = 1'b1;
    req      = '0;
    req_data = '0;
    req_last = '0;
    wr_full  = 1'b0;
    test_reset();
    test_single_stream();
    test_full_rotation();
    test_stall();
    test_early_drop();
    test_last_under_full();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
